rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
//
// PURPOSE
//  Parametrised N-channel registered multiplexer; successor to the gate-level 4:1 mux.
//  Round-robin arbitration picks one ready source per cycle; winning word is registered
//  onto a valid/ready output. Sits between N producer lanes and one shared datapath consumer.
//
// PARAMETERS
//  N_CH   4   number of input channels, >= 2, need not be a power of two
//  WIDTH  8   data bits per channel
//  SEL_W  2   channel index width, = $clog2(N_CH); set by instantiator, not checked in RTL
//
// PORTS
//  clk        in   1            single clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  in_valid   in   N_CH         per-channel request; bit i = channel i
//  in_ready   out  N_CH         per-channel accept; one-hot or zero
//  in_data    in   N_CH*WIDTH   channel i at [i*WIDTH +: WIDTH]
//  out_valid  out  1            registered output valid
//  out_ready  in   1            consumer accept
//  out_data   out  WIDTH        registered winning word
//  out_ch     out  SEL_W        index of channel that supplied out_data
//
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready=0 while rst=1.
//  - load = !out_valid | out_ready. Register stage advances only when load=1.
//  - Arbitration (combinational): scan channels ptr, ptr+1, ..., ptr+N_CH-1 (mod N_CH).
//    First channel k with in_valid[k]=1 wins. No valid input -> no winner.
//  - in_ready[k] = load & winner==k & !rst. All other in_ready bits are 0.
//  - Transfer: in_valid[k] & in_ready[k]. On the next edge: out_data<=in_data[k],
//    out_ch<=k, out_valid<=1, ptr<=(k==N_CH-1)?0:k+1.
//  - load=1 and no winner: out_valid<=0. out_data, out_ch and ptr hold.
//  - load=0 (out_valid=1 and out_ready=0): out_valid, out_data, out_ch hold.
//    No in_ready is asserted.
//  - Latency 1 cycle input to output. Throughput 1 word/cycle with out_ready held at 1.
//  - Fairness: a channel held valid is granted within N_CH transfers.
//  - Wrap: ptr wraps from N_CH-1 to 0. Non-power-of-two N_CH never selects index >= N_CH.
//  - Simultaneous out_ready=1 and a new winner: old word leaves and new word loads
//    in the same edge (no bubble).
//  - Reset mid-transfer: the pending word is dropped and ptr returns to 0.
//    No in_ready is asserted during reset.
//  - Sources must hold in_valid/in_data until accepted. The block does not check this.
//
// CONFIGURATION
//  RRMUX_FORCE_SEL_EN defined:
//    - Adds ports force_en (in, 1) and force_sel (in, SEL_W).
//    - When force_en=1, only channel force_sel is eligible. This gives legacy static-select
//      mux behaviour with a register stage.
//    - In this mode ptr is not updated on a transfer.
//    - force_sel >= N_CH gives no winner.
//  RRMUX_FORCE_SEL_EN undefined:
//    - The two ports are absent. Arbitration is pure round-robin as above.
//
// TESTING
//  1. rst pulse mid-cycle -> out_valid=0, out_data=0, out_ch=0, in_ready=0 immediately
//     (async). After release, first grant comes from ch0.
//  2. N_CH=4, all valid, out_ready=1, data i=8'hA0+i -> out_ch sequence 0,1,2,3,0.
//     out_data A0..A3,A0 on consecutive cycles with no bubbles.
//  3. Only ch2 valid (8'h5C), out_ready=0 for 3 cycles -> out_valid=1 and out_data=5C
//     held stable. in_ready=0 throughout. One transfer when out_ready=1.
//  4. N_CH=3, ch2 then ch0/ch1 valid -> grants 2,0,1, confirming wrap with no illegal index.
//  5. Output full, out_ready=1, ch1 valid (8'h11) -> same edge replaces the word with 11.
//     out_ch=1, out_valid stays 1.
//  6. RRMUX_FORCE_SEL_EN: force_en=1, force_sel=3, all valid -> only ch3 granted and ptr unchanged.
//     force_sel=3 with N_CH=3 -> out_valid=0.

Source files
------------

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: N producer lanes in, one registered valid/ready word out
interface rr_arb_mux_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
) ();
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [N_CH*WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: round-robin N-channel mux with registered valid/ready output; RRMUX_FORCE_SEL_EN adds force_en/force_sel static select
module rr_arb_mux #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
) (
    input logic             clk,
    input logic             rst,
`ifdef RRMUX_FORCE_SEL_EN
    input logic             force_en,
    input logic [SEL_W-1:0] force_sel,
`endif
    rr_arb_mux_if.slave     bus
);
    logic [SEL_W-1:0] ptr, win_idx, out_ch;
    logic [N_CH-1:0]  elig, ge_mask, hi, grant;
    logic [WIDTH-1:0] win_data, out_data;
    logic             has, load, hold_ptr, out_valid;

    assign load    = !out_valid || bus.out_ready;
    assign ge_mask = ~((N_CH'(1) << ptr) - N_CH'(1));
`ifdef RRMUX_FORCE_SEL_EN
    // out-of-range force_sel shifts the one-hot out of the vector, leaving nothing eligible
    assign elig     = force_en ? bus.in_valid & (N_CH'(1) << force_sel) : bus.in_valid;
    assign hold_ptr = force_en;
`else
    assign elig     = bus.in_valid;
    assign hold_ptr = 1'b0;
`endif
    assign hi = elig & ge_mask;
    assign has = |elig;

    // lowest eligible channel at or above ptr wins, otherwise lowest eligible overall
    always_comb begin
        win_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) if (elig[k]) win_idx = SEL_W'(k);
        for (int k = N_CH - 1; k >= 0; k--) if (hi[k]) win_idx = SEL_W'(k);
    end

    // one-hot grant and AND-OR select of the winning word
    always_comb begin
        grant    = '0;
        win_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            grant[k] = has && (win_idx == SEL_W'(k));
            win_data = win_data | (bus.in_data[k*WIDTH +: WIDTH] & {WIDTH{grant[k]}});
        end
    end

    assign bus.in_ready  = grant & {N_CH{load && !rst}};
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_ch    = out_ch;

    // output register advances on load; pointer moves past the winner unless forced
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= has;
            if (has) begin
                out_data <= win_data;
                out_ch   <= win_idx;
                if (!hold_ptr) ptr <= (win_idx == SEL_W'(N_CH - 1)) ? '0 : win_idx + SEL_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed checks of rr_arb_mux with N_CH=4 and N_CH=3 instances
module tb_rr_arb_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_arb_mux_if #(.N_CH(4), .WIDTH(8), .SEL_W(2)) b4 ();
    rr_arb_mux_if #(.N_CH(3), .WIDTH(8), .SEL_W(2)) b3 ();

`ifdef RRMUX_FORCE_SEL_EN
    logic       f4_en = 1'b0, f3_en = 1'b0;
    logic [1:0] f4_sel = 2'd0, f3_sel = 2'd0;
`endif

    rr_arb_mux #(.N_CH(4), .WIDTH(8), .SEL_W(2)) dut4 (
        .clk(clk),
        .rst(rst),
`ifdef RRMUX_FORCE_SEL_EN
        .force_en(f4_en),
        .force_sel(f4_sel),
`endif
        .bus(b4.slave)
    );

    rr_arb_mux #(.N_CH(3), .WIDTH(8), .SEL_W(2)) dut3 (
        .clk(clk),
        .rst(rst),
`ifdef RRMUX_FORCE_SEL_EN
        .force_en(f3_en),
        .force_sel(f3_sel),
`endif
        .bus(b3.slave)
    );

    task automatic set_idle();
        b4.in_valid  = '0;
        b4.out_ready = 1'b0;
        b4.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        b3.in_valid  = '0;
        b3.out_ready = 1'b0;
        b3.in_data   = {8'hC2, 8'hC1, 8'hC0};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        repeat (2) @(negedge clk);
        n_chk++;
        if ({b4.out_valid, b4.out_ch, b4.out_data, b4.in_ready} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", {b4.out_valid, b4.out_ch, b4.out_data, b4.in_ready});
        end
        rst = 1'b0;
        b4.in_valid = 4'b0100;
        @(negedge clk);
        n_chk++;
        if ({b4.out_valid, b4.out_ch, b4.out_data} !== {1'b1, 2'd2, 8'hA2}) begin
            n_fail++;
            $display("FAIL pre_rst_load: got %h want %h", {b4.out_valid, b4.out_ch, b4.out_data}, {1'b1, 2'd2, 8'hA2});
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({b4.out_valid, b4.out_ch, b4.out_data, b4.in_ready} !== 15'h0) begin
            n_fail++;
            $display("FAIL async_rst: got %h want 0", {b4.out_valid, b4.out_ch, b4.out_data, b4.in_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        b4.in_valid = 4'hF;
        b4.out_ready = 1'b1;
        #1;
        n_chk++;
        if (b4.in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL post_rst_ready: got %b want 0001", b4.in_ready);
        end
        @(negedge clk);
        n_chk++;
        if ({b4.out_valid, b4.out_ch, b4.out_data} !== {1'b1, 2'd0, 8'hA0}) begin
            n_fail++;
            $display("FAIL post_rst_grant: got %h want %h", {b4.out_valid, b4.out_ch, b4.out_data}, {1'b1, 2'd0, 8'hA0});
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] ec;
        logic [3:0] er;
        do_reset();
        b4.in_valid = 4'hF;
        b4.out_ready = 1'b1;
        #1;
        n_chk++;
        if (b4.in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rr_first_ready: got %b want 0001", b4.in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ec = 2'(i % 4);
            er = 4'(1 << ((i + 1) % 4));
            n_chk++;
            if ({b4.out_valid, b4.out_ch, b4.out_data} !== {1'b1, ec, 8'hA0 + 8'(ec)}) begin
                n_fail++;
                $display("FAIL rr_out[%0d]: got %h want %h", i, {b4.out_valid, b4.out_ch, b4.out_data}, {1'b1, ec, 8'hA0 + 8'(ec)});
            end
            n_chk++;
            if (b4.in_ready !== er) begin
                n_fail++;
                $display("FAIL rr_ready[%0d]: got %b want %b", i, b4.in_ready, er);
            end
        end
        b4.in_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        b4.in_data[23:16] = 8'h5C;
        b4.in_valid = 4'b0100;
        #1;
        n_chk++;
        if (b4.in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_first_ready: got %b want 0100", b4.in_ready);
        end
        @(negedge clk);
        b4.in_data[23:16] = 8'h5D;
        for (int j = 0; j < 3; j++) begin
            n_chk++;
            if ({b4.out_valid, b4.out_ch, b4.out_data, b4.in_ready} !== {1'b1, 2'd2, 8'h5C, 4'b0000}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %h want %h", j, {b4.out_valid, b4.out_ch, b4.out_data, b4.in_ready}, {1'b1, 2'd2, 8'h5C, 4'b0000});
            end
            @(negedge clk);
        end
        b4.out_ready = 1'b1;
        #1;
        n_chk++;
        if (b4.in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 0100", b4.in_ready);
        end
        @(negedge clk);
        n_chk++;
        if ({b4.out_valid, b4.out_ch, b4.out_data} !== {1'b1, 2'd2, 8'h5D}) begin
            n_fail++;
            $display("FAIL bp_next_word: got %h want %h", {b4.out_valid, b4.out_ch, b4.out_data}, {1'b1, 2'd2, 8'h5D});
        end
        b4.in_valid = '0;
        @(negedge clk);
        n_chk++;
        if ({b4.out_valid, b4.out_ch, b4.out_data} !== {1'b0, 2'd2, 8'h5D}) begin
            n_fail++;
            $display("FAIL bp_drain: got %h want %h", {b4.out_valid, b4.out_ch, b4.out_data}, {1'b0, 2'd2, 8'h5D});
        end
    endtask

    task automatic test_wrap_n3();
        logic [1:0] seq [4] = '{2'd2, 2'd0, 2'd1, 2'd0};
        do_reset();
        b3.in_valid = 3'b100;
        b3.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b3.in_valid = 3'b011;
            n_chk++;
            if ({b3.out_valid, b3.out_ch, b3.out_data} !== {1'b1, seq[i], 8'hC0 + 8'(seq[i])}) begin
                n_fail++;
                $display("FAIL wrap3[%0d]: got %h want %h", i, {b3.out_valid, b3.out_ch, b3.out_data}, {1'b1, seq[i], 8'hC0 + 8'(seq[i])});
            end
        end
        b3.in_valid = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        b4.in_valid = 4'b0001;
        @(negedge clk);
        n_chk++;
        if ({b4.out_valid, b4.out_ch, b4.out_data} !== {1'b1, 2'd0, 8'hA0}) begin
            n_fail++;
            $display("FAIL b2b_fill: got %h want %h", {b4.out_valid, b4.out_ch, b4.out_data}, {1'b1, 2'd0, 8'hA0});
        end
        b4.in_valid = 4'b0010;
        b4.in_data[15:8] = 8'h11;
        b4.out_ready = 1'b1;
        #1;
        n_chk++;
        if (b4.in_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b want 0010", b4.in_ready);
        end
        @(negedge clk);
        n_chk++;
        if ({b4.out_valid, b4.out_ch, b4.out_data} !== {1'b1, 2'd1, 8'h11}) begin
            n_fail++;
            $display("FAIL b2b_replace: got %h want %h", {b4.out_valid, b4.out_ch, b4.out_data}, {1'b1, 2'd1, 8'h11});
        end
        b4.in_valid = '0;
    endtask

`ifdef RRMUX_FORCE_SEL_EN
    task automatic test_force();
        do_reset();
        f4_en = 1'b1;
        f4_sel = 2'd3;
        b4.in_valid = 4'hF;
        b4.out_ready = 1'b1;
        #1;
        n_chk++;
        if (b4.in_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL force_ready: got %b want 1000", b4.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if ({b4.out_valid, b4.out_ch, b4.out_data} !== {1'b1, 2'd3, 8'hA3}) begin
                n_fail++;
                $display("FAIL force_out[%0d]: got %h want %h", i, {b4.out_valid, b4.out_ch, b4.out_data}, {1'b1, 2'd3, 8'hA3});
            end
        end
        f4_en = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({b4.out_valid, b4.out_ch, b4.out_data} !== {1'b1, 2'd0, 8'hA0}) begin
            n_fail++;
            $display("FAIL force_ptr_kept: got %h want %h", {b4.out_valid, b4.out_ch, b4.out_data}, {1'b1, 2'd0, 8'hA0});
        end
        b4.in_valid = '0;
        f3_en = 1'b1;
        f3_sel = 2'd3;
        b3.in_valid = 3'b111;
        b3.out_ready = 1'b1;
        #1;
        n_chk++;
        if (b3.in_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL force_oor_ready: got %b want 000", b3.in_ready);
        end
        @(negedge clk);
        n_chk++;
        if (b3.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL force_oor_valid: got %b want 0", b3.out_valid);
        end
        f3_en = 1'b0;
        b3.in_valid = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap_n3();
        test_back_to_back();
`ifdef RRMUX_FORCE_SEL_EN
        test_force();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
